alu_issue_stage: RTL and testbench

Operand-fetch and writeback stage feeding the 64-bit combinational ALU. It holds a 32-entry × 64-bit register file and accepts one instruction per cycle over a valid/ready handshake. Each instruction reads two operands (or one operand plus an immediate), registers them with the function-select code into an issue slot that drives the ALU, then writes the ALU result back to the destination register on the following edge. A single-entry bypass resolves back-to-back dependencies.

---
 rtl/alu_pkg.sv | 36 +++
 rtl/alu_regfile.sv | 31 +++
 rtl/alu_issue_stage.sv | 121 ++++++++++++
 tb/tb_alu_issue_stage.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU issue stage and its register file.
package alu_pkg;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned NREGS  = 32;

  localparam logic [4:0] FS_NOT_A  = 5'h00;
  localparam logic [4:0] FS_AND    = 5'h01;
  localparam logic [4:0] FS_ADD    = 5'h02;
  localparam logic [4:0] FS_SUB    = 5'h03;
  localparam logic [4:0] FS_OR     = 5'h04;
  localparam logic [4:0] FS_XOR    = 5'h05;
  localparam logic [4:0] FS_NOT_B  = 5'h06;
  localparam logic [4:0] FS_ADDC   = 5'h07;
  localparam logic [4:0] FS_SUBB   = 5'h08;
  localparam logic [4:0] FS_INC    = 5'h09;
  localparam logic [4:0] FS_DEC    = 5'h0A;
  localparam logic [4:0] FS_PASS_A = 5'h0B;
  localparam logic [4:0] FS_PASS_B = 5'h0C;
  localparam logic [4:0] FS_SHL    = 5'h0D;
  localparam logic [4:0] FS_SHR    = 5'h0E;

  localparam logic [4:0] LAST_FSEC = FS_SHR;

  typedef struct packed {
    logic [4:0]        fsec;
    logic              carry;
    logic [ADDR_W-1:0] rd;
  } issue_slot_t;

  function automatic logic fsec_legal(input logic [4:0] fsec);
    return (fsec <= LAST_FSEC);
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// 32 x 64-bit register file: two combinational read ports, one write port, r0 hardwired to zero.
module alu_regfile
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata
);

  logic [DATA_W-1:0] mem_q [NREGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we && (waddr != '0)) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata_a = (raddr_a == '0) ? '0 : mem_q[raddr_a];
  assign rdata_b = (raddr_b == '0) ? '0 : mem_q[raddr_b];

endmodule

// File: rtl/alu_issue_stage.sv
// Operand fetch, issue slot and writeback around an external combinational 64-bit ALU.
module alu_issue_stage
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_fsec,
  input  logic [ADDR_W-1:0] in_rs_a,
  input  logic [ADDR_W-1:0] in_rs_b,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic              in_use_imm,
  input  logic [DATA_W-1:0] in_imm,
  input  logic              in_carry,
  input  logic              stall,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [4:0]        alu_fsec,
  output logic              alu_carry,
  input  logic [DATA_W-1:0] alu_result,
  output logic              wb_valid,
  output logic [ADDR_W-1:0] wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              illegal_op,
  output logic [31:0]       retired_cnt
);

  issue_slot_t       slot_q;
  logic              issue_valid_q;
  logic [DATA_W-1:0] alu_a_q, alu_b_q;
  logic              wb_valid_q;
  logic [ADDR_W-1:0] wb_rd_q;
  logic [DATA_W-1:0] wb_data_q;
  logic              illegal_q;
  logic [31:0]       cnt_q;

  logic              accept, retire, commit, rf_we;
  logic              byp_a, byp_b;
  logic [DATA_W-1:0] rf_rdata_a, rf_rdata_b;
  logic [DATA_W-1:0] op_a, op_b;

  assign in_ready = !stall;
  assign accept   = in_valid && !stall;
  assign retire   = issue_valid_q && !stall;
  assign commit   = retire && fsec_legal(slot_q.fsec);
  assign rf_we    = commit && (slot_q.rd != '0);

  // Forward only what is actually being written this edge, so r0 and illegal slots never bypass.
  assign byp_a = rf_we && (slot_q.rd == in_rs_a);
  assign byp_b = rf_we && (slot_q.rd == in_rs_b);

  always_comb begin
    op_a = byp_a ? alu_result : rf_rdata_a;
    op_b = byp_b ? alu_result : rf_rdata_b;
    if (in_use_imm) begin
      op_b = in_imm;
    end
  end

  alu_regfile u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .raddr_a (in_rs_a),
    .raddr_b (in_rs_b),
    .rdata_a (rf_rdata_a),
    .rdata_b (rf_rdata_b),
    .we      (rf_we),
    .waddr   (slot_q.rd),
    .wdata   (alu_result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q        <= '0;
      issue_valid_q <= 1'b0;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
    end else if (accept) begin
      slot_q        <= '{fsec: in_fsec, carry: in_carry, rd: in_rd};
      issue_valid_q <= 1'b1;
      alu_a_q       <= op_a;
      alu_b_q       <= op_b;
    end else if (retire) begin
      issue_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      illegal_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      wb_valid_q <= commit;
      if (commit) begin
        wb_rd_q   <= slot_q.rd;
        wb_data_q <= alu_result;
      end
      if (retire) begin
        cnt_q <= cnt_q + 32'd1;
        if (!fsec_legal(slot_q.fsec)) begin
          illegal_q <= 1'b1;
        end
      end
    end
  end

  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_fsec    = slot_q.fsec;
  assign alu_carry   = slot_q.carry;
  assign wb_valid    = wb_valid_q;
  assign wb_rd       = wb_rd_q;
  assign wb_data     = wb_data_q;
  assign illegal_op  = illegal_q;
  assign retired_cnt = cnt_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: architectural model plus hand-computed checkpoints.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [4:0]  in_fsec;
  logic [4:0]  in_rs_a, in_rs_b, in_rd;
  logic        in_use_imm;
  logic [63:0] in_imm;
  logic        in_carry, stall;
  logic [63:0] alu_a, alu_b, alu_result;
  logic [4:0]  alu_fsec;
  logic        alu_carry;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic        illegal_op;
  logic [31:0] retired_cnt;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_issue_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_fsec     (in_fsec),
    .in_rs_a     (in_rs_a),
    .in_rs_b     (in_rs_b),
    .in_rd       (in_rd),
    .in_use_imm  (in_use_imm),
    .in_imm      (in_imm),
    .in_carry    (in_carry),
    .stall       (stall),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_fsec    (alu_fsec),
    .alu_carry   (alu_carry),
    .alu_result  (alu_result),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .illegal_op  (illegal_op),
    .retired_cnt (retired_cnt)
  );

  // Stand-in for the external ALU; the illegal-code result is deliberately nonzero.
  function automatic logic [63:0] alu_fn(input logic [4:0] f, input logic [63:0] a,
                                         input logic [63:0] b, input logic c);
    case (f)
      5'h00:   return ~a;
      5'h01:   return a & b;
      5'h02:   return a + b;
      5'h03:   return a - b;
      5'h07:   return a + b + {63'd0, c};
      default: return a ^ b ^ 64'h5a5a_0000_0000_0001;
    endcase
  endfunction

  assign alu_result = alu_fn(alu_fsec, alu_a, alu_b, alu_carry);

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, got, exp);
    end
  endtask

  // Architectural model: the in-flight instruction commits to ref_rf before the next one reads.
  logic [63:0] ref_rf [32];
  logic        m_busy, m_carry, m_illegal, m_wb_valid;
  logic [4:0]  m_fsec, m_rd, m_wb_rd;
  logic [63:0] m_a, m_b, m_wb_data, m_res;
  logic [31:0] m_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) ref_rf[i] = '0;
      m_busy = 0; m_carry = 0; m_illegal = 0; m_wb_valid = 0;
      m_fsec = 0; m_rd = 0; m_wb_rd = 0; m_a = 0; m_b = 0; m_wb_data = 0; m_cnt = 0;
    end else if (!stall) begin
      m_wb_valid = 0;
      if (m_busy) begin
        m_res = alu_fn(m_fsec, m_a, m_b, m_carry);
        m_cnt = m_cnt + 1;
        if (m_fsec > 5'd14) begin
          m_illegal = 1;
        end else begin
          m_wb_valid = 1;
          m_wb_rd    = m_rd;
          m_wb_data  = m_res;
          if (m_rd != 0) ref_rf[m_rd] = m_res;
        end
        m_busy = 0;
      end
      if (in_valid) begin
        m_a     = ref_rf[in_rs_a];
        m_b     = in_use_imm ? in_imm : ref_rf[in_rs_b];
        m_fsec  = in_fsec;
        m_carry = in_carry;
        m_rd    = in_rd;
        m_busy  = 1;
      end
    end else begin
      m_wb_valid = 0;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("in_ready", {63'd0, in_ready}, {63'd0, !stall});
      check("alu_a", alu_a, m_a);
      check("alu_b", alu_b, m_b);
      check("alu_fsec", {59'd0, alu_fsec}, {59'd0, m_fsec});
      check("alu_carry", {63'd0, alu_carry}, {63'd0, m_carry});
      check("wb_valid", {63'd0, wb_valid}, {63'd0, m_wb_valid});
      if (m_wb_valid) begin
        check("wb_rd", {59'd0, wb_rd}, {59'd0, m_wb_rd});
        check("wb_data", wb_data, m_wb_data);
      end
      check("illegal_op", {63'd0, illegal_op}, {63'd0, m_illegal});
      check("retired_cnt", {32'd0, retired_cnt}, {32'd0, m_cnt});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] f, input logic [4:0] ra, input logic [4:0] rb,
                       input logic [4:0] rd, input logic ui, input logic [63:0] imm,
                       input logic c);
    in_valid = 1; in_fsec = f; in_rs_a = ra; in_rs_b = rb; in_rd = rd;
    in_use_imm = ui; in_imm = imm; in_carry = c;
  endtask

  initial begin
    rst_n = 0; in_valid = 0; in_fsec = 0; in_rs_a = 0; in_rs_b = 0; in_rd = 0;
    in_use_imm = 0; in_imm = 0; in_carry = 0; stall = 0;
    step(); step();
    rst_n = 1;
    check("rst_alu_a", alu_a, 64'd0);
    check("rst_wb_valid", {63'd0, wb_valid}, 64'd0);
    check("rst_cnt", {32'd0, retired_cnt}, 64'd0);

    // Reset-then-read: r1+r2 -> r3
    drive(5'h02, 5'd1, 5'd2, 5'd3, 0, 64'd0, 0); step(); in_valid = 0;
    check("rd_after_rst_a", alu_a, 64'd0);
    check("rd_after_rst_b", alu_b, 64'd0);
    step();
    check("first_wb_valid", {63'd0, wb_valid}, 64'd1);
    check("first_wb_rd", {59'd0, wb_rd}, 64'd3);
    check("first_wb_data", wb_data, 64'd0);

    // Immediate load then dependent back-to-back op: r1=5, r2=12
    drive(5'h02, 5'd0, 5'd0, 5'd1, 1, 64'd5, 0); step();
    drive(5'h02, 5'd1, 5'd0, 5'd2, 1, 64'd7, 0); step();
    check("bypass_a", alu_a, 64'd5);
    check("imm_b", alu_b, 64'd7);
    in_valid = 0; step();
    check("imm_wb_rd", {59'd0, wb_rd}, 64'd2);
    check("imm_wb_data", wb_data, 64'd12);

    // Operand-B bypass with carry: r6 = 13, r7 = 5 + 13 + 1
    drive(5'h02, 5'd2, 5'd0, 5'd6, 1, 64'd1, 0); step();
    drive(5'h07, 5'd1, 5'd6, 5'd7, 0, 64'd0, 1); step();
    check("bypass_b", alu_b, 64'd13);
    in_valid = 0; step();
    check("addc_wb_data", wb_data, 64'd19);

    // Stall for three edges with a slot holding r1+r2 -> r8, next instruction waiting
    drive(5'h02, 5'd1, 5'd2, 5'd8, 0, 64'd0, 0); step();
    stall = 1;
    drive(5'h02, 5'd8, 5'd0, 5'd9, 1, 64'd1, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_ready", {63'd0, in_ready}, 64'd0);
      check("stall_wb", {63'd0, wb_valid}, 64'd0);
      check("stall_a", alu_a, 64'd5);
      check("stall_b", alu_b, 64'd12);
    end
    stall = 0; step();
    check("release_cnt", {32'd0, retired_cnt}, 64'd6);
    check("release_wb", wb_data, 64'd17);
    check("release_bypass", alu_a, 64'd17);
    in_valid = 0; step();
    check("held_instr_cnt", {32'd0, retired_cnt}, 64'd7);

    // Illegal code into r4, then an immediate read of r4 must see 0 (no bypass)
    drive(5'h10, 5'd1, 5'd0, 5'd4, 1, 64'd3, 0); step();
    drive(5'h02, 5'd4, 5'd0, 5'd10, 1, 64'd0, 0); step();
    check("illegal_no_wb", {63'd0, wb_valid}, 64'd0);
    check("illegal_set", {63'd0, illegal_op}, 64'd1);
    check("illegal_cnt", {32'd0, retired_cnt}, 64'd8);
    check("r4_unchanged", alu_a, 64'd0);
    in_valid = 0; step();
    check("illegal_sticky", {63'd0, illegal_op}, 64'd1);

    // r0 destination: writeback pulses, but no write and no bypass
    drive(5'h00, 5'd0, 5'd0, 5'd0, 0, 64'd0, 0); step();
    drive(5'h02, 5'd0, 5'd0, 5'd11, 1, 64'd0, 0); step();
    check("r0_wb_valid", {63'd0, wb_valid}, 64'd1);
    check("r0_wb_rd", {59'd0, wb_rd}, 64'd0);
    check("r0_wb_data", wb_data, 64'hffff_ffff_ffff_ffff);
    check("r0_no_bypass", alu_a, 64'd0);
    in_valid = 0; step();
    check("r0_cnt", {32'd0, retired_cnt}, 64'd11);

    // Reset between accept and retire
    drive(5'h02, 5'd1, 5'd0, 5'd12, 1, 64'd1, 0); step(); in_valid = 0;
    #2 rst_n = 0;
    #1;
    check("midrst_a", alu_a, 64'd0);
    check("midrst_b", alu_b, 64'd0);
    check("midrst_fsec", {59'd0, alu_fsec}, 64'd0);
    check("midrst_wb", {63'd0, wb_valid}, 64'd0);
    check("midrst_cnt", {32'd0, retired_cnt}, 64'd0);
    check("midrst_illegal", {63'd0, illegal_op}, 64'd0);
    step(); step();
    rst_n = 1;
    drive(5'h02, 5'd1, 5'd8, 5'd13, 0, 64'd0, 0); step(); in_valid = 0;
    check("post_rst_r1", alu_a, 64'd0);
    check("post_rst_r8", alu_b, 64'd0);
    step();
    check("post_rst_wb", {63'd0, wb_valid}, 64'd1);
    check("post_rst_data", wb_data, 64'd0);
    check("post_rst_cnt", {32'd0, retired_cnt}, 64'd1);
    step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
